// File: rtl/layer_ctl_gen.sv
// Command/data byte decoder for the LED cube SPI stream.
// Ports: byte stream in (dc/cs/strobe/data); RAM strobes, address, lanes, frame/err status out.
module layer_ctl_gen #(
  parameter int          LAYERS       = 8,
  parameter int          PIXELS       = 64,
  parameter int          COLORS       = 3,
  parameter logic [7:0]  CMD_CONF_WR  = 8'h2a,
  parameter logic [7:0]  CMD_ADDR_WR  = 8'h2b,
  parameter logic [7:0]  CMD_DATA_WR  = 8'h2c,
  parameter logic [7:0]  CMD_LAYER_WR = 8'h2d,
  localparam int         ADDR_W       = (PIXELS > 1) ? $clog2(PIXELS) : 1
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              dc_in,
  input  logic              spi_cs_n_in,
  input  logic              byte_rdy_in,
  input  logic [7:0]        byte_data_in,
  output logic [LAYERS-1:0] wr_en_out,
  output logic [ADDR_W-1:0] wr_addr_out,
  output logic [COLORS+1:0] byte_en_out,
  output logic              frame_rdy_out,
  output logic              err_out,
  output logic [7:0]        frame_cnt_out
);

  localparam int BW = COLORS + 2;
  localparam logic [BW-1:0] LANE_CONF = BW'(1) << (COLORS + 1);
  localparam logic [BW-1:0] LANE_ADDR = BW'(1) << COLORS;
  localparam logic [BW-1:0] LANE_TOP  = BW'(1) << (COLORS - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIXELS - 1);
  localparam logic [LAYERS-1:0] MASK_TOP  = LAYERS'(1) << (LAYERS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CONF, S_ADDR, S_DATA, S_LSEL, S_LDATA, S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [LAYERS-1:0] mask_q, mask_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [BW-1:0]     ben_q, ben_d;
  logic              frdy_q, frdy_d;
  logic              err_q, err_d;
  logic [7:0]        fcnt_q, fcnt_d;
  logic              cs_q;

  logic cs_fall, is_cmd, is_dat, wr_state, addr_last;

  assign cs_fall   = cs_q & ~spi_cs_n_in;
  assign is_cmd    = byte_rdy_in & ~dc_in;
  assign is_dat    = byte_rdy_in & dc_in;
  assign addr_last = (addr_q == LAST_ADDR);
  assign wr_state  = (state_q == S_CONF) | (state_q == S_ADDR) |
                     (state_q == S_DATA) | (state_q == S_LDATA);

  // A byte that arrives with the cs falling edge is dropped.
  assign wr_en_out = mask_q &
    {LAYERS{is_dat & ~cs_fall & wr_state}};

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    addr_d  = addr_q;
    ben_d   = ben_q;
    err_d   = err_q;
    frdy_d  = 1'b0;
    fcnt_d  = fcnt_q;
    if (cs_fall) begin
      state_d = S_IDLE;
      mask_d  = '0;
      addr_d  = '0;
      ben_d   = '0;
      err_d   = 1'b0;
    end else if (is_cmd) begin
      addr_d = '0;
      unique case (1'b1)
        (byte_data_in == CMD_CONF_WR): begin
          state_d = S_CONF;
          mask_d  = '1;
          ben_d   = LANE_CONF;
        end
        (byte_data_in == CMD_ADDR_WR): begin
          state_d = S_ADDR;
          mask_d  = '1;
          ben_d   = LANE_ADDR;
        end
        (byte_data_in == CMD_DATA_WR): begin
          state_d = S_DATA;
          mask_d  = MASK_TOP;
          ben_d   = LANE_TOP;
        end
        (byte_data_in == CMD_LAYER_WR): begin
          state_d = S_LSEL;
          mask_d  = '0;
          ben_d   = '0;
        end
        default: begin
          state_d = S_IDLE;
          mask_d  = '0;
          ben_d   = '0;
        end
      endcase
    end else if (is_dat) begin
      unique case (state_q)
        S_CONF, S_ADDR: begin
          if (addr_last) begin
            state_d = S_IDLE;
            mask_d  = '0;
            addr_d  = '0;
            ben_d   = '0;
          end else begin
            addr_d = addr_q + ADDR_W'(1);
          end
        end
        S_DATA, S_LDATA: begin
          if (ben_q[0]) begin
            ben_d  = LANE_TOP;
            addr_d = addr_last ? '0 : addr_q + ADDR_W'(1);
            if (addr_last) begin
              // Full frame walks layers top-down.
              if (state_q == S_DATA && !mask_q[0]) begin
                mask_d = mask_q >> 1;
              end else begin
                state_d = S_DONE;
                mask_d  = '0;
                ben_d   = '0;
                frdy_d  = 1'b1;
                fcnt_d  = fcnt_q + 8'd1;
              end
            end
          end else begin
            ben_d = ben_q >> 1;
          end
        end
        S_LSEL: begin
          if (32'(byte_data_in) < 32'(LAYERS)) begin
            state_d = S_LDATA;
            mask_d  = LAYERS'(1) << byte_data_in;
            ben_d   = LANE_TOP;
          end else begin
            state_d = S_IDLE;
            err_d   = 1'b1;
          end
        end
        default: err_d = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= S_IDLE;
      mask_q  <= '0;
      addr_q  <= '0;
      ben_q   <= '0;
      frdy_q  <= 1'b0;
      err_q   <= 1'b0;
      fcnt_q  <= '0;
      cs_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      addr_q  <= addr_d;
      ben_q   <= ben_d;
      frdy_q  <= frdy_d;
      err_q   <= err_d;
      fcnt_q  <= fcnt_d;
      cs_q    <= spi_cs_n_in;
    end
  end

  assign wr_addr_out   = addr_q;
  assign byte_en_out   = ben_q;
  assign frame_rdy_out = frdy_q;
  assign err_out       = err_q;
  assign frame_cnt_out = fcnt_q;

endmodule

// File: tb/tb_layer_ctl_gen.sv
// Bench for layer_ctl_gen: three parameter sets driven in parallel,
// each checked every cycle against a byte-count reference model.
module tb_layer_ctl_gen;

  localparam int M_IDLE = 0, M_CONF = 1, M_ADDR = 2, M_DATA = 3,
                 M_LSEL = 4, M_LDATA = 5, M_DONE = 6;

  typedef struct {
    int mode;
    int k;
    int lsel;
    bit err;
    int fcnt;
    bit frdy;
    bit pcs;
  } mdl_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cs_n = 1'b1;
  logic rdy = 1'b0;
  logic dc = 1'b0;
  logic [7:0] data = 8'h00;

  int n_tests = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  logic [7:0] w0; logic [5:0] a0; logic [4:0] b0;
  logic [3:0] w1; logic [3:0] a1; logic [5:0] b1;
  logic [1:0] w2; logic [0:0] a2; logic [2:0] b2;
  logic f0, f1, f2, e0, e1, e2;
  logic [7:0] c0, c1, c2;

  layer_ctl_gen u0 (
    .clk_in(clk), .rst_n_in(rst_n), .dc_in(dc),
    .spi_cs_n_in(cs_n), .byte_rdy_in(rdy), .byte_data_in(data),
    .wr_en_out(w0), .wr_addr_out(a0), .byte_en_out(b0),
    .frame_rdy_out(f0), .err_out(e0), .frame_cnt_out(c0));

  layer_ctl_gen #(.LAYERS(4), .PIXELS(16), .COLORS(4)) u1 (
    .clk_in(clk), .rst_n_in(rst_n), .dc_in(dc),
    .spi_cs_n_in(cs_n), .byte_rdy_in(rdy), .byte_data_in(data),
    .wr_en_out(w1), .wr_addr_out(a1), .byte_en_out(b1),
    .frame_rdy_out(f1), .err_out(e1), .frame_cnt_out(c1));

  layer_ctl_gen #(.LAYERS(2), .PIXELS(2), .COLORS(1)) u2 (
    .clk_in(clk), .rst_n_in(rst_n), .dc_in(dc),
    .spi_cs_n_in(cs_n), .byte_rdy_in(rdy), .byte_data_in(data),
    .wr_en_out(w2), .wr_addr_out(a2), .byte_en_out(b2),
    .frame_rdy_out(f2), .err_out(e2), .frame_cnt_out(c2));

  logic [31:0] ow [3];
  logic [31:0] oa [3];
  logic [31:0] ob [3];
  logic [31:0] of [3];
  logic [31:0] oe [3];
  logic [31:0] oc [3];

  assign ow[0] = 32'(w0); assign ow[1] = 32'(w1); assign ow[2] = 32'(w2);
  assign oa[0] = 32'(a0); assign oa[1] = 32'(a1); assign oa[2] = 32'(a2);
  assign ob[0] = 32'(b0); assign ob[1] = 32'(b1); assign ob[2] = 32'(b2);
  assign of[0] = 32'(f0); assign of[1] = 32'(f1); assign of[2] = 32'(f2);
  assign oe[0] = 32'(e0); assign oe[1] = 32'(e1); assign oe[2] = 32'(e2);
  assign oc[0] = 32'(c0); assign oc[1] = 32'(c1); assign oc[2] = 32'(c2);

  int pl [3] = '{8, 4, 2};
  int pp [3] = '{64, 16, 2};
  int pc [3] = '{3, 4, 1};
  mdl_t m [3];
  int cyc = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic mdl_t mdl_reset();
    mdl_t s;
    s.mode = M_IDLE; s.k = 0; s.lsel = 0; s.err = 0;
    s.fcnt = 0; s.frdy = 0; s.pcs = 1;
    return s;
  endfunction

  // Layer for full-frame byte k counts down from the top layer.
  function automatic logic [31:0] exp_wr(mdl_t s, int L, int P, int C,
                                         bit fall, bit r, bit d_c);
    if (fall || !r || !d_c) return 32'd0;
    case (s.mode)
      M_CONF, M_ADDR: return 32'((64'd1 << L) - 64'd1);
      M_DATA:  return 32'd1 << (L - 1 - s.k / (P * C));
      M_LDATA: return 32'd1 << s.lsel;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] exp_addr(mdl_t s, int P, int C);
    case (s.mode)
      M_CONF, M_ADDR: return 32'(s.k);
      M_DATA, M_LDATA: return 32'((s.k / C) % P);
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] exp_ben(mdl_t s, int C);
    case (s.mode)
      M_CONF: return 32'd1 << (C + 1);
      M_ADDR: return 32'd1 << C;
      M_DATA, M_LDATA: return 32'd1 << (C - 1 - s.k % C);
      default: return 32'd0;
    endcase
  endfunction

  function automatic mdl_t step(mdl_t s, int L, int P, int C,
                                bit c, bit r, bit d_c, logic [7:0] d);
    mdl_t n = s;
    n.frdy = 0;
    n.pcs = c;
    if (s.pcs && !c) begin
      n.mode = M_IDLE; n.k = 0; n.err = 0;
    end else if (r && !d_c) begin
      n.k = 0;
      case (d)
        8'h2a: n.mode = M_CONF;
        8'h2b: n.mode = M_ADDR;
        8'h2c: n.mode = M_DATA;
        8'h2d: n.mode = M_LSEL;
        default: n.mode = M_IDLE;
      endcase
    end else if (r && d_c) begin
      case (s.mode)
        M_CONF, M_ADDR: begin
          n.k = s.k + 1;
          if (n.k == P) begin n.mode = M_IDLE; n.k = 0; end
        end
        M_DATA, M_LDATA: begin
          n.k = s.k + 1;
          if (n.k == ((s.mode == M_DATA) ? L * P * C : P * C)) begin
            n.mode = M_DONE; n.k = 0; n.frdy = 1;
            n.fcnt = (s.fcnt + 1) % 256;
          end
        end
        M_LSEL: begin
          if (int'(d) < L) begin
            n.lsel = int'(d); n.mode = M_LDATA; n.k = 0;
          end else begin
            n.err = 1; n.mode = M_IDLE;
          end
        end
        default: n.err = 1;
      endcase
    end
    return n;
  endfunction

  task automatic compare_all();
    for (int i = 0; i < 3; i++) begin
      bit fall;
      fall = m[i].pcs && !cs_n;
      check($sformatf("u%0d wr_en", i), ow[i],
            exp_wr(m[i], pl[i], pp[i], pc[i], fall, rdy, dc));
      check($sformatf("u%0d addr", i), oa[i], exp_addr(m[i], pp[i], pc[i]));
      check($sformatf("u%0d byte_en", i), ob[i], exp_ben(m[i], pc[i]));
      check($sformatf("u%0d frame_rdy", i), of[i], 32'(m[i].frdy));
      check($sformatf("u%0d err", i), oe[i], 32'(m[i].err));
      check($sformatf("u%0d frame_cnt", i), oc[i], 32'(m[i].fcnt));
    end
  endtask

  task automatic cycle(input bit c, input bit r, input bit d_c,
                       input logic [7:0] d);
    @(negedge clk);
    cyc++;
    cs_n = c; rdy = r; dc = d_c; data = d;
    #1;
    compare_all();
    for (int i = 0; i < 3; i++)
      m[i] = step(m[i], pl[i], pp[i], pc[i], c, r, d_c, d);
  endtask

  task automatic send_cmd(input logic [7:0] d);
    cycle(1'b0, 1'b1, 1'b0, d);
  endtask

  task automatic send_dat(input logic [7:0] d);
    cycle(1'b0, 1'b1, 1'b1, d);
  endtask

  task automatic send_rnd(input int n);
    for (int j = 0; j < n; j++) send_dat(8'($urandom));
  endtask

  task automatic cs_pulse(input bit strobe);
    cycle(1'b1, 1'b0, 1'b0, 8'h00);
    cycle(1'b0, strobe, 1'b1, 8'h5a);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) m[i] = mdl_reset();
    #1;
    compare_all();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    cs_pulse(1'b0);

    send_cmd(8'h2c);
    send_rnd(1536);
    cycle(1'b0, 1'b0, 1'b0, 8'h00);

    send_cmd(8'h2a);
    send_rnd(65);

    send_cmd(8'h2d);
    send_dat(8'h03);
    send_rnd(192);
    cycle(1'b0, 1'b0, 1'b0, 8'h00);
    send_cmd(8'h2d);
    send_dat(8'h08);
    send_rnd(4);

    cs_pulse(1'b1);
    send_dat(8'h11);

    send_cmd(8'h2c);
    send_rnd(100);
    send_cmd(8'h2b);
    send_rnd(20);
    send_cmd(8'h77);
    send_dat(8'h01);

    for (int f = 0; f < 256; f++) begin
      send_cmd(8'h2c);
      send_rnd(4);
    end
    cycle(1'b0, 1'b0, 1'b0, 8'h00);

    for (int j = 0; j < 4000; j++) begin
      bit r, d_c, c;
      logic [7:0] d;
      int cmd_odds;
      cmd_odds = (j < 1500) ? 24 : 400;
      r = $urandom_range(0, 3) != 0;
      d_c = $urandom_range(0, cmd_odds - 1) != 0;
      c = $urandom_range(0, 299) == 0;
      if (!d_c) begin
        case ($urandom_range(0, 4))
          0: d = 8'h2a;
          1: d = 8'h2b;
          2: d = 8'h2c;
          3: d = 8'h2d;
          default: d = 8'($urandom);
        endcase
      end else if ($urandom_range(0, 1) == 0) begin
        d = 8'($urandom_range(0, 9));
      end else begin
        d = 8'($urandom);
      end
      cycle(c, r, d_c, d);
    end

    send_cmd(8'h2c);
    send_rnd(37);
    @(negedge clk);
    cs_n = 1'b0; rdy = 1'b1; dc = 1'b1; data = 8'h33;
    #2;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) m[i] = mdl_reset();
    #1;
    compare_all();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b0, 1'b0, 1'b0, 8'h00);
    send_dat(8'h44);
    cycle(1'b0, 1'b0, 1'b0, 8'h00);
    cycle(1'b0, 1'b0, 1'b0, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
